// File: rtl/wb_pkg.sv
// Shared widths, state encoding and command/response records for the
// Wishbone command master.
package wb_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } wb_mst_state_t;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_SW-1:0] sel;
  } wb_cmd_t;

  typedef struct packed {
    logic [WB_DW-1:0] data;
    logic             err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and pulses
// o_expired in the cycle the count reaches TIMEOUT-1.
module wb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + 1'b1;
    end
  end

  assign o_expired = i_enable && (count == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding pipelined Wishbone master: one command in, one bus cycle,
// one response out, with a watchdog that forces an error response.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [WB_AW-1:0] i_cmd_addr,
  input  logic [WB_DW-1:0] i_cmd_data,
  input  logic [WB_SW-1:0] i_cmd_sel,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WB_DW-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [WB_SW-1:0] o_wb_sel,
  input  logic             i_wb_stall,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  input  logic [WB_DW-1:0] i_wb_data
);

  wb_mst_state_t state;
  wb_cmd_t       cmd_q;
  wb_rsp_t       rsp_q;
  logic          rsp_valid_q;
  logic          cyc_q;
  logic          stb_q;
  logic          accept;
  logic          in_bus_cycle;
  logic          timed_out;

  assign accept       = (state == IDLE) && i_cmd_valid;
  assign in_bus_cycle = (state == REQ) || (state == WAIT);

  wb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (accept),
    .i_enable (in_bus_cycle),
    .o_expired(timed_out)
  );

  // NOTE: the registered command doubles as the bus address/data/sel, so it
  // is reset explicitly to give the bus a defined value out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            cmd_q <= '{we: i_cmd_we, addr: i_cmd_addr, data: i_cmd_data, sel: i_cmd_sel};
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            state <= REQ;
          end
        end
        REQ, WAIT: begin
          // ack/err during a stalled strobe still counts as acceptance
          if (i_wb_err || (!i_wb_ack && timed_out)) begin
            rsp_q       <= '{data: '0, err: 1'b1};
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state       <= RSP;
          end else if (i_wb_ack) begin
            rsp_q       <= '{data: (cmd_q.we ? '0 : i_wb_data), err: 1'b0};
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            state       <= RSP;
          end else if ((state == REQ) && !i_wb_stall) begin
            stb_q <= 1'b0;
            state <= WAIT;
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_q.we    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (state == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_q.data;
  assign o_rsp_err   = rsp_q.err;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = cmd_q.we;
  assign o_wb_addr   = cmd_q.addr;
  assign o_wb_data   = cmd_q.data;
  assign o_wb_sel    = cmd_q.sel;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: the slave side is driven cycle by cycle
// from the stimulus sequence, with hand-computed expectations.
module tb_wb_cmd_master;
  import wb_pkg::*;

  localparam int TIMEOUT = 8;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_we;
  logic [WB_AW-1:0] i_cmd_addr;
  logic [WB_DW-1:0] i_cmd_data;
  logic [WB_SW-1:0] i_cmd_sel;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [WB_DW-1:0] o_rsp_data;
  logic             o_rsp_err;
  logic             o_wb_cyc;
  logic             o_wb_stb;
  logic             o_wb_we;
  logic [WB_AW-1:0] o_wb_addr;
  logic [WB_DW-1:0] o_wb_data;
  logic [WB_SW-1:0] o_wb_sel;
  logic             i_wb_stall;
  logic             i_wb_ack;
  logic             i_wb_err;
  logic [WB_DW-1:0] i_wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  wb_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_we   (i_cmd_we),
    .i_cmd_addr (i_cmd_addr),
    .i_cmd_data (i_cmd_data),
    .i_cmd_sel  (i_cmd_sel),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data (o_rsp_data),
    .o_rsp_err  (o_rsp_err),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_addr  (o_wb_addr),
    .o_wb_data  (o_wb_data),
    .o_wb_sel   (o_wb_sel),
    .i_wb_stall (i_wb_stall),
    .i_wb_ack   (i_wb_ack),
    .i_wb_err   (i_wb_err),
    .i_wb_data  (i_wb_data)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a command for one edge; returns in cycle 1 of the transaction.
  task automatic issue(input logic we, input logic [29:0] addr, input logic [31:0] data);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    i_cmd_sel   = 4'hF;
    step();
    i_cmd_valid = 1'b0;
  endtask

  initial begin
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_data  = '0;
    i_cmd_sel   = '0;
    i_rsp_ready = 1'b1;
    i_wb_stall  = 1'b1;
    i_wb_ack    = 1'b0;
    i_wb_err    = 1'b0;
    i_wb_data   = '0;
    step();
    step();
    i_reset = 1'b0;

    // Reset state
    check1("rst_cmd_ready", o_cmd_ready, 1'b1);
    check1("rst_rsp_valid", o_rsp_valid, 1'b0);
    check1("rst_rsp_err", o_rsp_err, 1'b0);
    check32("rst_rsp_data", o_rsp_data, 32'h0);
    check1("rst_cyc", o_wb_cyc, 1'b0);
    check1("rst_stb", o_wb_stb, 1'b0);
    check1("rst_we", o_wb_we, 1'b0);
    check32("rst_addr", 32'(o_wb_addr), 32'h0);

    // Write 0xA5 to address 0 against a stall-idles-high slave
    issue(1'b1, 30'd0, 32'h0000_00A5);
    check1("wr_c1_cyc", o_wb_cyc, 1'b1);
    check1("wr_c1_stb", o_wb_stb, 1'b1);
    check1("wr_c1_we", o_wb_we, 1'b1);
    check32("wr_c1_data", o_wb_data, 32'h0000_00A5);
    check32("wr_c1_sel", 32'(o_wb_sel), 32'hF);
    check1("wr_c1_cmd_ready", o_cmd_ready, 1'b0);
    step();
    i_wb_ack = 1'b1;
    check1("wr_c2_stb", o_wb_stb, 1'b1);
    check1("wr_c2_rsp_valid", o_rsp_valid, 1'b0);
    step();
    i_wb_ack = 1'b0;
    check1("wr_c3_rsp_valid", o_rsp_valid, 1'b1);
    check1("wr_c3_rsp_err", o_rsp_err, 1'b0);
    check32("wr_c3_rsp_data", o_rsp_data, 32'h0);
    check1("wr_c3_cyc", o_wb_cyc, 1'b0);
    step();
    check1("wr_c4_cmd_ready", o_cmd_ready, 1'b1);
    check1("wr_c4_rsp_valid", o_rsp_valid, 1'b0);

    // Read address 3, slave returns 0x40; stray data after ack must not leak
    issue(1'b0, 30'd3, 32'h0);
    check32("rd_c1_addr", 32'(o_wb_addr), 32'd3);
    check1("rd_c1_we", o_wb_we, 1'b0);
    step();
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h0000_0040;
    step();
    i_wb_ack  = 1'b0;
    i_wb_data = 32'hDEAD_BEEF;
    check1("rd_rsp_valid", o_rsp_valid, 1'b1);
    check32("rd_rsp_data", o_rsp_data, 32'h0000_0040);
    check1("rd_rsp_err", o_rsp_err, 1'b0);
    check1("rd_cyc_low", o_wb_cyc, 1'b0);
    step();

    // Timeout: stall low drops to WAIT, no ack ever arrives
    i_wb_stall = 1'b0;
    issue(1'b0, 30'h2A, 32'h0);
    for (int c = 1; c <= TIMEOUT; c++) begin
      check1("to_pending_rsp_valid", o_rsp_valid, 1'b0);
      check1("to_pending_cyc", o_wb_cyc, 1'b1);
      if (c == 2) check1("to_wait_stb", o_wb_stb, 1'b0);
      step();
    end
    check1("to_rsp_valid", o_rsp_valid, 1'b1);
    check1("to_rsp_err", o_rsp_err, 1'b1);
    check32("to_rsp_data", o_rsp_data, 32'h0);
    check1("to_cyc", o_wb_cyc, 1'b0);
    step();

    // Slave stalls for 5 strobe cycles, then acks with stall still high
    i_wb_stall = 1'b1;
    issue(1'b1, 30'h15, 32'h1234_5678);
    for (int c = 1; c <= 5; c++) begin
      check1("st_stb_held", o_wb_stb, 1'b1);
      check32("st_addr_held", 32'(o_wb_addr), 32'h15);
      check1("st_no_rsp", o_rsp_valid, 1'b0);
      step();
    end
    i_wb_ack = 1'b1;
    check1("st_c6_stb", o_wb_stb, 1'b1);
    step();
    i_wb_ack = 1'b0;
    check1("st_rsp_valid", o_rsp_valid, 1'b1);
    check1("st_rsp_err", o_rsp_err, 1'b0);
    check32("st_addr_in_rsp", 32'(o_wb_addr), 32'h15);
    step();
    check1("st_single_rsp", o_rsp_valid, 1'b0);
    check1("st_no_dup_stb", o_wb_stb, 1'b0);
    check1("st_no_dup_cyc", o_wb_cyc, 1'b0);

    // ack and err together: err wins; then response backpressure
    i_rsp_ready = 1'b0;
    issue(1'b0, 30'd5, 32'h0);
    step();
    i_wb_ack  = 1'b1;
    i_wb_err  = 1'b1;
    i_wb_data = 32'hFFFF_FFFF;
    step();
    i_wb_ack    = 1'b0;
    i_wb_err    = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = 30'd7;
    i_cmd_data  = 32'h0;
    i_cmd_sel   = 4'h3;
    for (int c = 0; c < 3; c++) begin
      check1("ae_rsp_valid", o_rsp_valid, 1'b1);
      check1("ae_rsp_err", o_rsp_err, 1'b1);
      check32("ae_rsp_data", o_rsp_data, 32'h0);
      check1("bp_cmd_ready", o_cmd_ready, 1'b0);
      check1("bp_cyc", o_wb_cyc, 1'b0);
      if (c == 2) i_rsp_ready = 1'b1;
      step();
    end
    check1("bp_released_cmd_ready", o_cmd_ready, 1'b1);
    check1("bp_released_rsp_valid", o_rsp_valid, 1'b0);
    step();
    i_cmd_valid = 1'b0;
    check1("bp_next_cyc", o_wb_cyc, 1'b1);
    check32("bp_next_addr", 32'(o_wb_addr), 32'd7);
    check32("bp_next_sel", 32'(o_wb_sel), 32'h3);
    step();
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h0000_0077;
    step();
    i_wb_ack = 1'b0;
    check32("bp_next_rsp_data", o_rsp_data, 32'h0000_0077);
    check1("bp_next_rsp_err", o_rsp_err, 1'b0);
    step();

    // Stray ack/err while idle is ignored
    i_wb_ack = 1'b1;
    i_wb_err = 1'b1;
    step();
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    check1("stray_rsp_valid", o_rsp_valid, 1'b0);
    check1("stray_cmd_ready", o_cmd_ready, 1'b1);

    // Reset pulsed in WAIT drops the in-flight command
    i_wb_stall = 1'b0;
    issue(1'b0, 30'd9, 32'h0);
    step();
    check1("rw_wait_cyc", o_wb_cyc, 1'b1);
    check1("rw_wait_stb", o_wb_stb, 1'b0);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check1("rw_cyc", o_wb_cyc, 1'b0);
    check1("rw_rsp_valid", o_rsp_valid, 1'b0);
    check1("rw_cmd_ready", o_cmd_ready, 1'b1);
    step();
    check1("rw_no_late_rsp", o_rsp_valid, 1'b0);

    // Read after reset completes normally
    i_wb_stall = 1'b1;
    issue(1'b0, 30'hA, 32'h0);
    check32("ar_addr", 32'(o_wb_addr), 32'hA);
    step();
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hCAFE_F00D;
    step();
    i_wb_ack = 1'b0;
    check1("ar_rsp_valid", o_rsp_valid, 1'b1);
    check32("ar_rsp_data", o_rsp_data, 32'hCAFE_F00D);
    check1("ar_rsp_err", o_rsp_err, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
